i_ref_sweep: RTL and testbench

- Generates the current-reference stimulus consumed by `i_ref_sampling`.
- Ramps `i_ref` from a programmable start value in fixed steps. Holds each step for a settle interval, then issues a one-cycle `ready` strobe.
- Stops on the first `went_unstable` report or when the next step would exceed the limit. On instability it parks `i_ref` at the last stable value.
- Sits upstream of `i_ref_sampling`, driving its `i_ref`/`ready` inputs, and shares `went_unstable` with it.

---
 rtl/i_ref_pkg.sv | 18 +
 rtl/settle_counter.sv | 38 +++
 rtl/i_ref_sweep.sv | 149 ++++++++++++++
 tb/tb_i_ref_sweep.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i_ref_pkg.sv
// Shared types and defaults for the current-reference sweep
// and its downstream sampler.
package i_ref_pkg;

    localparam int unsigned I_REF_BUS_WIDTH = 10;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        STROBE,
        DONE
    } sweep_state_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/settle_counter.sv
// Loadable down-counter timing how long i_ref is held before ready.
// Saturates at zero so a paused STROBE entry cannot wrap it.
module settle_counter
    import i_ref_pkg::*;
#(
    parameter int unsigned WIDTH = cnt_width(4)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/i_ref_sweep.sv
// Ramps the current reference in settled steps and strobes ready,
// stopping on instability (parked at last stable value) or the limit.
module i_ref_sweep
    import i_ref_pkg::*;
#(
    parameter int unsigned BUS_WIDTH     = I_REF_BUS_WIDTH,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 start,
    input  logic                 went_unstable,
    input  logic [BUS_WIDTH-1:0] i_ref_start,
    input  logic [BUS_WIDTH-1:0] i_ref_step,
    input  logic [BUS_WIDTH-1:0] i_ref_limit,
    output logic [BUS_WIDTH-1:0] i_ref,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic                 unstable_hit,
    output logic                 limit_hit
);

    localparam int unsigned CW = cnt_width(SETTLE_CYCLES);
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

    sweep_state_t state_q, state_d;
    logic [BUS_WIDTH-1:0] iref_q, iref_d;
    logic [BUS_WIDTH-1:0] stable_q, stable_d;
    logic [BUS_WIDTH-1:0] step_q, step_d;
    logic [BUS_WIDTH-1:0] limit_q, limit_d;
    logic unstable_q, unstable_d;
    logic uhit_q, uhit_d;
    logic lhit_q, lhit_d;

    logic cnt_load;
    logic cnt_en;
    logic cnt_zero;
    logic wu;
    logic [BUS_WIDTH:0] next_sum;
    logic over;

    // An undriven or unknown monitor output must not end a sweep.
    assign wu = (went_unstable === 1'b1);

    assign next_sum = {1'b0, iref_q} + {1'b0, step_q};
    assign over     = (next_sum > {1'b0, limit_q});

    settle_counter #(
        .WIDTH(CW)
    ) u_settle_counter (
        .clk_i     (clk),
        .rst_i     (rst),
        .load_i    (cnt_load),
        .en_i      (cnt_en),
        .load_val_i(RELOAD),
        .zero_o    (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        iref_d     = iref_q;
        stable_d   = stable_q;
        step_d     = step_q;
        limit_d    = limit_q;
        unstable_d = unstable_q;
        uhit_d     = uhit_q;
        lhit_d     = lhit_q;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;

        if (((state_q == SETTLE) || (state_q == STROBE)) && wu) begin
            unstable_d = 1'b1;
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (start && enable) begin
                    state_d    = SETTLE;
                    iref_d     = i_ref_start;
                    stable_d   = '0;
                    step_d     = (i_ref_step == '0) ? BUS_WIDTH'(1) : i_ref_step;
                    limit_d    = i_ref_limit;
                    unstable_d = 1'b0;
                    uhit_d     = 1'b0;
                    lhit_d     = 1'b0;
                    cnt_load   = 1'b1;
                end
            end
            SETTLE: begin
                if (enable) begin
                    cnt_en = 1'b1;
                    if (cnt_zero) begin
                        state_d = STROBE;
                    end
                end
            end
            STROBE: begin
                if (enable) begin
                    if (unstable_q || wu) begin
                        state_d = DONE;
                        iref_d  = stable_q;
                        uhit_d  = 1'b1;
                    end else if (over) begin
                        state_d  = DONE;
                        stable_d = iref_q;
                        lhit_d   = 1'b1;
                    end else begin
                        state_d  = SETTLE;
                        stable_d = iref_q;
                        iref_d   = next_sum[BUS_WIDTH-1:0];
                        cnt_load = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            iref_q     <= '0;
            stable_q   <= '0;
            step_q     <= '0;
            limit_q    <= '0;
            unstable_q <= 1'b0;
            uhit_q     <= 1'b0;
            lhit_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            iref_q     <= iref_d;
            stable_q   <= stable_d;
            step_q     <= step_d;
            limit_q    <= limit_d;
            unstable_q <= unstable_d;
            uhit_q     <= uhit_d;
            lhit_q     <= lhit_d;
        end
    end

    assign i_ref        = iref_q;
    assign ready        = (state_q == STROBE) && enable;
    assign busy         = (state_q == SETTLE) || (state_q == STROBE);
    assign done         = (state_q == DONE);
    assign unstable_hit = uhit_q;
    assign limit_hit    = lhit_q;

endmodule

// File: tb/tb_i_ref_sweep.sv
// Self-checking bench for i_ref_sweep: directed vector table, hand-written
// pause/reset sequences and randomized sweeps against a step-list model.
module tb_i_ref_sweep;

    localparam int BW = 10;
    localparam int SC = 4;
    localparam int P  = SC + 1;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic start;
    logic went_unstable;
    logic [BW-1:0] i_ref_start;
    logic [BW-1:0] i_ref_step;
    logic [BW-1:0] i_ref_limit;
    logic [BW-1:0] i_ref;
    logic ready;
    logic busy;
    logic done;
    logic unstable_hit;
    logic limit_hit;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i_ref_sweep #(
        .BUS_WIDTH    (BW),
        .SETTLE_CYCLES(SC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .start        (start),
        .went_unstable(went_unstable),
        .i_ref_start  (i_ref_start),
        .i_ref_step   (i_ref_step),
        .i_ref_limit  (i_ref_limit),
        .i_ref        (i_ref),
        .ready        (ready),
        .busy         (busy),
        .done         (done),
        .unstable_hit (unstable_hit),
        .limit_hit    (limit_hit)
    );

    typedef struct {
        int s;
        int st;
        int lim;
        int u;
        int n;
        int fin;
        int uh;
        int lh;
    } vec_t;

    vec_t vecs[9];

    bit pause_at[0:8191];
    bit unst_at[0:8191];

    int got_off[$];
    int got_val[$];
    int exp_val[$];
    int exp_off[$];
    int done_off;
    int exp_done;
    int exp_fin;
    int exp_uh;
    int exp_lh;
    int o1_iref;
    int o1_busy;
    int o1_flags;
    bit prev_rdy = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ready) begin
            checks++;
            if (prev_rdy) begin
                errors++;
                $display("FAIL ready_isolated: got 2 consecutive, expected 1");
            end
        end
        prev_rdy = ready;
    end

    task automatic clear_stim();
        for (int i = 0; i < 8192; i++) begin
            pause_at[i] = 1'b0;
            unst_at[i]  = 1'b0;
        end
    endtask

    // Reference: list of strobe values from plain arithmetic; an
    // instability seen in step j ends the sweep at that step's strobe.
    task automatic model(input int s, input int st, input int lim, input int u);
        int stp;
        int v;
        int j;
        int ju;
        int prev;
        stp  = (st == 0) ? 1 : st;
        v    = s;
        j    = 0;
        prev = 0;
        ju   = (u > 0) ? (u - 1) / P : 1000000;
        exp_val.delete();
        exp_off.delete();
        while (1) begin
            exp_val.push_back(v);
            exp_off.push_back(P + P * j);
            if (j == ju) begin
                exp_fin = prev;
                exp_uh  = 1;
                exp_lh  = 0;
                break;
            end
            if (v + stp > lim) begin
                exp_fin = v;
                exp_uh  = 0;
                exp_lh  = 1;
                break;
            end
            prev = v;
            v    = v + stp;
            j++;
        end
        exp_done = P * exp_val.size() + 1;
    endtask

    task automatic run(input int s, input int st, input int lim, input int tmo);
        got_off.delete();
        got_val.delete();
        done_off = -1;
        @(posedge clk);
        #1;
        start       = 1'b1;
        i_ref_start = BW'(s);
        i_ref_step  = BW'(st);
        i_ref_limit = BW'(lim);
        for (int off = 1; off <= tmo; off++) begin
            @(posedge clk);
            #1;
            start         = 1'b0;
            enable        = !pause_at[off];
            went_unstable = unst_at[off];
            @(negedge clk);
            if (off == 1) begin
                o1_iref  = int'(i_ref);
                o1_busy  = int'(busy);
                o1_flags = int'({unstable_hit, limit_hit, done});
            end
            if (ready) begin
                got_off.push_back(off);
                got_val.push_back(int'(i_ref));
            end
            if (done) begin
                done_off = off;
                break;
            end
        end
        enable        = 1'b1;
        went_unstable = 1'b0;
    endtask

    task automatic verify(input int s);
        check("start_i_ref", o1_iref, s);
        check("start_busy", o1_busy, 1);
        check("start_flags", o1_flags, 0);
        check("strobe_count", got_off.size(), exp_val.size());
        for (int j = 0; j < got_off.size() && j < exp_val.size(); j++) begin
            check("strobe_value", got_val[j], exp_val[j]);
            check("strobe_cycle", got_off[j], exp_off[j]);
        end
        check("done_cycle", done_off, exp_done);
        check("final_i_ref", int'(i_ref), exp_fin);
        check("unstable_hit", int'(unstable_hit), exp_uh);
        check("limit_hit", int'(limit_hit), exp_lh);
        check("busy_at_done", int'(busy), 0);
    endtask

    initial begin
        int s;
        int st;
        int lim;
        int u;

        vecs[0] = '{100, 50, 300, 0, 5, 300, 0, 1};
        vecs[1] = '{100, 50, 300, 12, 3, 150, 1, 0};
        vecs[2] = '{100, 50, 300, 0, 5, 300, 0, 1};
        vecs[3] = '{100, 50, 300, 2, 1, 0, 1, 0};
        vecs[4] = '{1000, 30, 1023, 0, 1, 1000, 0, 1};
        vecs[5] = '{5, 0, 8, 0, 4, 8, 0, 1};
        vecs[6] = '{600, 10, 500, 0, 1, 600, 0, 1};
        vecs[7] = '{100, 50, 300, 15, 3, 150, 1, 0};
        vecs[8] = '{1023, 0, 1023, 0, 1, 1023, 0, 1};

        rst           = 1'b1;
        enable        = 1'b1;
        start         = 1'b0;
        went_unstable = 1'b0;
        i_ref_start   = '0;
        i_ref_step    = '0;
        i_ref_limit   = '0;
        clear_stim();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              int'({i_ref, ready, busy, done, unstable_hit, limit_hit}), 0);

        foreach (vecs[i]) begin
            clear_stim();
            if (vecs[i].u > 0) unst_at[vecs[i].u] = 1'b1;
            model(vecs[i].s, vecs[i].st, vecs[i].lim, vecs[i].u);
            exp_fin = vecs[i].fin;
            exp_uh  = vecs[i].uh;
            exp_lh  = vecs[i].lh;
            run(vecs[i].s, vecs[i].st, vecs[i].lim, 4000);
            check("table_strobe_count", got_off.size(), vecs[i].n);
            verify(vecs[i].s);
        end

        // Reset while parked in DONE with a flag set.
        clear_stim();
        unst_at[3] = 1'b1;
        model(100, 50, 300, 3);
        run(100, 50, 300, 4000);
        verify(100);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_from_done",
              int'({i_ref, ready, busy, done, unstable_hit, limit_hit}), 0);

        // Pause 3 cycles mid-settle, instability reported while paused.
        clear_stim();
        pause_at[2] = 1'b1;
        pause_at[3] = 1'b1;
        pause_at[4] = 1'b1;
        unst_at[3]  = 1'b1;
        exp_val = '{100};
        exp_off = '{8};
        exp_done = 9;
        exp_fin  = 0;
        exp_uh   = 1;
        exp_lh   = 0;
        run(100, 50, 300, 4000);
        verify(100);

        // Pause across a strobe: ready drops, then the strobe repeats.
        clear_stim();
        pause_at[5] = 1'b1;
        exp_val = '{100, 150};
        exp_off = '{6, 11};
        exp_done = 12;
        exp_fin  = 150;
        exp_uh   = 0;
        exp_lh   = 1;
        run(100, 50, 150, 4000);
        check("paused_strobe_ready", (got_off.size() > 0) ? got_off[0] : -1, 6);
        verify(100);

        // Start while busy is ignored; reset mid-settle aborts.
        @(posedge clk);
        #1;
        start       = 1'b1;
        i_ref_start = 10'd100;
        i_ref_step  = 10'd50;
        i_ref_limit = 10'd300;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start       = 1'b1;
        i_ref_start = 10'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("start_while_busy_i_ref", int'(i_ref), 100);
        check("start_while_busy_busy", int'(busy), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_mid_settle",
              int'({i_ref, ready, busy, done, unstable_hit, limit_hit}), 0);

        for (int k = 0; k < 25; k++) begin
            s  = int'($urandom_range(0, 1023));
            st = int'($urandom_range(0, 100));
            if ($urandom_range(0, 4) == 0) begin
                lim = int'($urandom_range(0, 1023));
            end else if (st < 8) begin
                lim = s + int'($urandom_range(0, 40));
            end else begin
                lim = s + int'($urandom_range(0, 300));
            end
            if (lim > 1023) lim = 1023;
            u = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 60));
            clear_stim();
            if (u > 0) unst_at[u] = 1'b1;
            model(s, st, lim, u);
            run(s, st, lim, 4000);
            verify(s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
